// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared encodings and sizing helpers for the vector engine
package vec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_SQRT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic OP_LEN = 1'b0;
    localparam logic OP_IP  = 1'b1;

    // Headroom for DIM_MAX saturated products plus a sign bit.
    function automatic int acc_width(input int n, input int dim_max);
        return n + $clog2(dim_max) + 1;
    endfunction

endpackage

// File: rtl/vec_engine_if.sv
// rtl/vec_engine_if.sv - request/result bundle between a requester and vec_engine
interface vec_engine_if #(
    parameter int N       = 32,
    parameter int DIM_MAX = 4
);
    localparam int DW = $clog2(DIM_MAX + 1);

    logic                 start;
    logic                 op;
    logic [DW-1:0]        dim;
    logic [DIM_MAX*N-1:0] a_flat;
    logic [DIM_MAX*N-1:0] b_flat;
    logic                 busy;
    logic                 done;
    logic [N-1:0]         result;
    logic                 overflow;
    logic                 err;

    modport master (
        output start, op, dim, a_flat, b_flat,
        input  busy, done, result, overflow, err
    );

    modport slave (
        input  start, op, dim, a_flat, b_flat,
        output busy, done, result, overflow, err
    );

endinterface

// File: rtl/vec_engine_isqrt_seq.sv
// rtl/vec_engine_isqrt_seq.sv - restoring bit-serial integer square root, one root bit per cycle
module isqrt_seq #(
    parameter int W = 31
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_start,
    input  logic [2*W-1:0] i_radicand,
    output logic [W-1:0]   o_root,
    output logic           o_done
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int RW = W + 2;

    logic [2*W-1:0] r_rad;
    logic [RW-1:0]  r_rem;
    logic [W-1:0]   r_root;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic           r_done;

    logic [W+3:0]   w_rem_sh;
    logic [W+3:0]   w_trial;
    logic           w_fit;

    // Bring down the next two radicand bits and try appending a 1 to the root.
    assign w_rem_sh = {r_rem, r_rad[2*W-1 -: 2]};
    assign w_trial  = {2'b00, r_root, 2'b01};
    assign w_fit    = (w_rem_sh >= w_trial);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rad  <= '0;
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rad  <= i_radicand;
                r_rem  <= '0;
                r_root <= '0;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rad  <= r_rad << 2;
                r_rem  <= w_fit ? RW'(w_rem_sh - w_trial) : RW'(w_rem_sh);
                r_root <= {r_root[W-2:0], w_fit};
                if (r_cnt == CW'(W - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign o_root = r_root;
    assign o_done = r_done;

endmodule

// File: rtl/vec_engine.sv
// rtl/vec_engine.sv - sign-magnitude fixed-point vector length / inner product engine
module vec_engine
    import vec_pkg::*;
#(
    parameter int N       = 32,
    parameter int Q       = 15,
    parameter int DIM_MAX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    vec_engine_if.slave  bus
);
    localparam int DW    = $clog2(DIM_MAX + 1);
    localparam int IW    = $clog2(DIM_MAX);
    localparam int CW    = ($clog2(N) > DW) ? $clog2(N) : DW;
    localparam int ACC_W = acc_width(N, DIM_MAX);
    localparam int W     = N - 1;
    localparam logic [W-1:0] MAX_MAG = '1;

    state_t           r_state;
    logic             r_op;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    r_last;
    logic [N-1:0]     r_a [DIM_MAX];
    logic [N-1:0]     r_b [DIM_MAX];
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic             r_bad;
    logic [N-1:0]     r_pend;
    logic             r_busy;
    logic             r_done;
    logic [N-1:0]     r_result;
    logic             r_overflow;
    logic             r_err;

    logic [IW-1:0]    w_idx;
    logic [N-1:0]     w_x;
    logic [N-1:0]     w_y;
    logic [2*W-1:0]   w_full;
    logic [2*W-1:0]   w_shift;
    logic             w_prod_ovf;
    logic [W-1:0]     w_mag;
    logic [ACC_W-1:0] w_term_mag;
    logic [ACC_W-1:0] w_term;
    logic [ACC_W-1:0] w_acc_next;
    logic [ACC_W-1:0] w_abs;
    logic             w_big;
    logic [W-1:0]     w_sat;
    logic             w_neg;
    logic [2*W-1:0]   w_rad;
    logic             w_sq_start;
    logic             w_bad;
    logic [W-1:0]     w_root;
    logic             w_sq_done;

    assign w_idx      = r_cnt[IW-1:0];
    assign w_x        = r_a[w_idx];
    assign w_y        = (r_op == OP_IP) ? r_b[w_idx] : w_x;
    assign w_full     = {{W{1'b0}}, w_x[W-1:0]} * {{W{1'b0}}, w_y[W-1:0]};
    assign w_shift    = w_full >> Q;
    assign w_prod_ovf = |w_shift[2*W-1:W];
    assign w_mag      = w_prod_ovf ? MAX_MAG : w_shift[W-1:0];
    assign w_term_mag = {{(ACC_W-W){1'b0}}, w_mag};
    assign w_term     = (w_x[N-1] ^ w_y[N-1]) ? (~w_term_mag + ACC_W'(1)) : w_term_mag;
    assign w_acc_next = r_acc + w_term;

    // Final magnitude is taken from the sum including the element being added
    // this cycle, so the root can start on the same edge as the last MAC.
    assign w_abs      = w_acc_next[ACC_W-1] ? (~w_acc_next + ACC_W'(1)) : w_acc_next;
    assign w_big      = |w_abs[ACC_W-1:W];
    assign w_sat      = w_big ? MAX_MAG : w_abs[W-1:0];
    assign w_neg      = w_acc_next[ACC_W-1] && (w_sat != '0);
    assign w_rad      = {{W{1'b0}}, w_sat} << Q;

    assign w_sq_start = (r_state == ST_MAC) && (r_cnt == r_last) && (r_op == OP_LEN);
    assign w_bad      = (bus.dim == '0) || (bus.dim > DW'(DIM_MAX));

    isqrt_seq #(.W(W)) u_isqrt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_sq_start),
        .i_radicand (w_rad),
        .o_root     (w_root),
        .o_done     (w_sq_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_LEN;
            r_cnt      <= '0;
            r_last     <= '0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_bad      <= 1'b0;
            r_pend     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_op   <= bus.op;
                        r_last <= CW'(bus.dim) - CW'(1);
                        r_cnt  <= '0;
                        r_acc  <= '0;
                        r_ovf  <= 1'b0;
                        r_pend <= '0;
                        r_busy <= 1'b1;
                        for (int i = 0; i < DIM_MAX; i++) begin
                            r_a[i] <= bus.a_flat[i*N +: N];
                            r_b[i] <= bus.b_flat[i*N +: N];
                        end
                        r_bad   <= w_bad;
                        r_state <= w_bad ? ST_DONE : ST_MAC;
                    end
                end
                ST_MAC: begin
                    r_acc <= w_acc_next;
                    if (r_cnt == r_last) begin
                        r_ovf   <= r_ovf | w_prod_ovf | w_big;
                        r_pend  <= {w_neg, w_sat};
                        r_cnt   <= '0;
                        r_state <= (r_op == OP_LEN) ? ST_SQRT : ST_DONE;
                    end else begin
                        r_ovf <= r_ovf | w_prod_ovf;
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_SQRT: begin
                    // Mirrors the root's N-1 iterations so DONE lines up with its last bit.
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(N - 2)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_result   <= w_sq_done ? {1'b0, w_root} : r_pend;
                    r_overflow <= r_ovf;
                    r_err      <= r_bad;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.overflow = r_overflow;
    assign bus.err      = r_err;

endmodule

// File: doc/vec_engine.md
VEC_ENGINE -- requirements
Module: vec_engine

Interface
REQ-001 Parameter N, default 32: word width of every operand and result, sign-magnitude (MSB = sign, N-1 magnitude bits).
REQ-002 Parameter Q, default 15: fractional bits of the fixed-point format; legal range 1..N-2.
REQ-003 Parameter DIM_MAX, default 4: maximum vector dimension; legal range 2..16.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 start  input  1  request strobe; sampled only while busy=0.
REQ-007 op  input  1  0 = length of vector a, 1 = inner product a·b.
REQ-008 dim  input  $clog2(DIM_MAX+1)  number of active elements, 1..DIM_MAX.
REQ-009 a_flat  input  DIM_MAX*N  vector a; element i occupies bits [i*N +: N].
REQ-010 b_flat  input  DIM_MAX*N  vector b; ignored when op=0.
REQ-011 busy  output  1  high from the cycle after an accepted start until done.
REQ-012 done  output  1  single-cycle pulse marking a valid result.
REQ-013 result  output  N  sign-magnitude result; held stable until the next done.
REQ-014 overflow  output  1  saturation flag for the latest operation; updated with done.
REQ-015 err  output  1  illegal-dim flag; updated with done.

Function
REQ-016 States: IDLE, MAC, SQRT, DONE; encoded via shared constants.
REQ-017 IDLE + start=1: capture op, dim, a_flat, b_flat, clear accumulator and sticky overflow, go to MAC (or DONE with err=1 if dim=0 or dim>DIM_MAX).
REQ-018 start while busy=1 is ignored; no queuing.
REQ-019 MAC: one element per cycle, index 0..dim-1; product = (|x|*|y|)>>Q, truncated, sign = XOR of signs; x=y=a[i] for op=0.
REQ-020 Accumulator is two's complement, N+$clog2(DIM_MAX)+1 bits; products added with sign.
REQ-021 Any product magnitude ≥ 2^(N-1) sets sticky overflow and contributes saturated magnitude 2^(N-1)-1.
REQ-022 After element dim-1: op=1 -> DONE; op=0 -> SQRT.
REQ-023 Inner-product final: |acc| > 2^(N-1)-1 sets overflow, result = saturated max magnitude with acc sign; else sign-magnitude of acc; zero result has sign bit 0.
REQ-024 SQRT: restoring bit-serial integer square root of (acc<<Q), one result bit per cycle, exactly N-1 cycles; result sign = 0.
REQ-025 If acc exceeds 2^(N-1)-1 entering SQRT, overflow=1 and the root of the saturated value is computed.
REQ-026 DONE: assert done=1 for one cycle, drive result/overflow/err, return to IDLE; start is not accepted in DONE.
REQ-027 Latency, start edge to done: op=1 -> dim+1 cycles; op=0 -> dim+N cycles; illegal dim -> 1 cycle, result=0.
REQ-028 Outputs registered; no combinational path from inputs to outputs.

Reset
REQ-029 rst_n=0 at a clock edge: state=IDLE, busy=0, done=0, result=0, overflow=0, err=0, accumulator and root datapath cleared.
REQ-030 Reset mid-operation aborts it; no done pulse is produced for the aborted request.

Structure
REQ-031 Shared package vec_pkg holds state encodings, op encodings (OP_LEN=0, OP_IP=1) and the accumulator-width function.
REQ-032 One sub-module isqrt_seq (start/done handshake, width parameter) implements REQ-024; MAC and control stay in vec_engine.

Verification (N=32, Q=15; 1.0 = 0x00008000)
REQ-033 op=0, dim=2, a=(3.0,4.0)=(0x00018000,0x00020000) -> done after 34 cycles, result=0x00028000, overflow=0, err=0.
REQ-034 op=1, dim=2, a=(1.5,-2.0)=(0x0000C000,0x80010000), b=(2.0,0.5)=(0x00010000,0x00004000) -> done after 3 cycles, result=0x00010000.
REQ-035 op=1, dim=4, all a=b=0x7FFFFFFF -> overflow=1, result=0x7FFFFFFF.
REQ-036 dim=0 and dim=5 -> done after 1 cycle, err=1, result=0; next legal request has err=0.
REQ-037 Second start during busy -> ignored, exactly one done; rst_n=0 mid-SQRT -> outputs zero, no done, next request correct.
REQ-038 op=1, dim=1, a=(0x80008000), b=(0x00008000) -> result=0x80008000 (-1.0); a=(0x80000000), b=any -> result=0x00000000.
